// File: rtl/urng_fp64.sv
// Uniform random source: 64-bit xorshift -> IEEE 754 double in [2^-64, 1), tagged U1/U2.
// Latency 3 cycles (pushin at edge N -> pushout after edge N+2), one sample per cycle.
// No backpressure: the consumer must accept every pushout. Optional macro URNG_STATS_EN adds the count port.
module urng_fp64 #(
    parameter logic [63:0] SEED_DEF = 64'h9E3779B97F4A7C15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pushin,
    input  logic        seed_ld,
    input  logic [63:0] seed,
    output logic        pushout,
    output logic [63:0] num,
    output logic        sel
`ifdef URNG_STATS_EN
    ,
    output logic [31:0] count
`endif
);

    // Stage 1: generator state and registered sample
    logic [63:0] state_q, state_d;
    logic [63:0] r_q, r_d;
    logic        v1_q, v1_d;

    // Stage 2: leading-zero count alongside the raw sample
    logic [63:0] r2_q;
    logic [5:0]  lz_q, lz_d;
    logic        v2_q;

    // Stage 3: packed output and tag toggle
    logic [63:0] num_q, num_d;
    logic        sel_q, sel_d;
    logic        tog_q, tog_d;
    logic        pushout_q;

    // Xorshift step of the current state
    logic [63:0] xs1, xs2, xs3;
    assign xs1 = state_q ^ (state_q << 13);
    assign xs2 = xs1 ^ (xs1 >> 7);
    assign xs3 = xs2 ^ (xs2 << 17);

    // Seed load has priority over a sample request; a zero seed is replaced so the state never sticks at 0
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        v1_d    = 1'b0;
        if (seed_ld) begin
            state_d = (seed == 64'd0) ? SEED_DEF : seed;
        end else if (pushin) begin
            state_d = xs3;
            r_d     = xs3;
            v1_d    = 1'b1;
        end
    end

    // Stage 1 registers; reset restores the default seed and drops any pending sample
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= SEED_DEF;
            r_q     <= 64'd0;
            v1_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            v1_q    <= v1_d;
        end
    end

    // Leading-zero count: the highest set bit wins (r is never zero)
    always_comb begin
        lz_d = 6'd0;
        for (int i = 0; i < 64; i++) begin
            if (r_q[i]) begin
                lz_d = 6'(63 - i);
            end
        end
    end

    // Stage 2 registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r2_q <= 64'd0;
            lz_q <= 6'd0;
            v2_q <= 1'b0;
        end else begin
            r2_q <= r_q;
            lz_q <= lz_d;
            v2_q <= v1_q;
        end
    end

    // Normalise so the leading one lands in bit 63; the 52 bits below it form the
    // mantissa (zero-filled from the shift, excess low bits truncated)
    logic [63:0] norm;
    logic [10:0] exp_f;
    logic [63:0] packed_num;
    logic        unused_norm;
    assign norm        = r2_q << lz_q;
    assign exp_f       = 11'd1022 - {5'd0, lz_q};
    assign packed_num  = {1'b0, exp_f, norm[62:11]};
    assign unused_norm = ^{norm[63], norm[10:0]};

    // Output next-state: num/sel hold while idle, tag toggles after each emitted sample
    always_comb begin
        num_d = num_q;
        sel_d = sel_q;
        tog_d = tog_q;
        if (v2_q) begin
            num_d = packed_num;
            sel_d = tog_q;
            tog_d = ~tog_q;
        end
    end

    // Stage 3 output registers; the toggle survives seed loads, only reset clears it
    always_ff @(posedge clk) begin
        if (!rst) begin
            num_q     <= 64'd0;
            sel_q     <= 1'b0;
            tog_q     <= 1'b0;
            pushout_q <= 1'b0;
        end else begin
            num_q     <= num_d;
            sel_q     <= sel_d;
            tog_q     <= tog_d;
            pushout_q <= v2_q;
        end
    end

    assign pushout = pushout_q;
    assign num     = num_q;
    assign sel     = sel_q;

`ifdef URNG_STATS_EN
    logic [31:0] count_q, count_d;

    // Sample counter advances together with pushout, so it already includes the sample on display
    always_comb begin
        count_d = count_q;
        if (v2_q) begin
            count_d = count_q + 32'd1;
        end
    end

    // Counter register, cleared only by reset; wraps naturally
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
`endif

endmodule

// File: tb/tb_urng_fp64.sv
// Bench for urng_fp64: directed steps with a reference xorshift/pack model.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Define URNG_STATS_EN to also exercise the sample counter.
module tb_urng_fp64;

    localparam logic [63:0] SEED_DEF = 64'h9E3779B97F4A7C15;

    logic        clk = 1'b0;
    logic        rst;
    logic        pushin;
    logic        seed_ld;
    logic [63:0] seed;
    logic        pushout;
    logic [63:0] num;
    logic        sel;
`ifdef URNG_STATS_EN
    logic [31:0] count;
`endif

    always #5 clk = ~clk;

    urng_fp64 #(.SEED_DEF(SEED_DEF)) dut (
        .clk     (clk),
        .rst     (rst),
        .pushin  (pushin),
        .seed_ld (seed_ld),
        .seed    (seed),
        .pushout (pushout),
        .num     (num),
        .sel     (sel)
`ifdef URNG_STATS_EN
        ,
        .count   (count)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int t0;

    logic [63:0] cap_num[$];
    logic        cap_sel[$];
    int          cap_cyc[$];
    logic [31:0] cap_cnt[$];

    logic [63:0] m_state;
    logic        m_tog;
    logic [63:0] exp_num[$];
    logic        exp_sel[$];

    function automatic logic [63:0] m_xs(input logic [63:0] x);
        logic [63:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 7);
        y = y ^ (y << 17);
        return y;
    endfunction

    // Reference pack: locate the MSB, exponent 959+p, take the 52 bits under the MSB
    function automatic logic [63:0] m_pack(input logic [63:0] r);
        int          p;
        logic [51:0] m;
        logic [10:0] e;
        p = 0;
        for (int i = 0; i < 64; i++) if (r[i]) p = i;
        if (p >= 52) m = 52'(r >> (p - 52));
        else         m = 52'(r << (52 - p));
        e = 11'(959 + p);
        return {1'b0, e, m};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (pushout === 1'b1) begin
            cap_num.push_back(num);
            cap_sel.push_back(sel);
            cap_cyc.push_back(cyc);
`ifdef URNG_STATS_EN
            cap_cnt.push_back(count);
`else
            cap_cnt.push_back(32'd0);
`endif
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_sample();
        m_state = m_xs(m_state);
        exp_num.push_back(m_pack(m_state));
        exp_sel.push_back(m_tog);
        m_tog = ~m_tog;
    endtask

    task automatic clear_q();
        cap_num.delete(); cap_sel.delete(); cap_cyc.delete(); cap_cnt.delete();
        exp_num.delete(); exp_sel.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0; pushin = 1'b0; seed_ld = 1'b0; seed = 64'd0;
        tick(); tick();
        rst = 1'b1;
        m_state = SEED_DEF;
        m_tog   = 1'b0;
        clear_q();
    endtask

    task automatic compare_caps(input string tag);
        chk({tag, "_nsamples"}, 64'(cap_num.size()), 64'(exp_num.size()));
        for (int i = 0; i < cap_num.size() && i < exp_num.size(); i++) begin
            chk($sformatf("%s_num[%0d]", tag, i), cap_num[i], exp_num[i]);
            chk($sformatf("%s_sel[%0d]", tag, i), 64'(cap_sel[i]), 64'(exp_sel[i]));
        end
    endtask

    initial begin
        rst = 1'b0; pushin = 1'b0; seed_ld = 1'b0; seed = 64'd0;
        tick(); tick(); tick();
        // Reset state
        chk("rst_pushout", 64'(pushout), 64'd0);
        chk("rst_num", num, 64'd0);
        chk("rst_sel", 64'(sel), 64'd0);
`ifdef URNG_STATS_EN
        chk("rst_count", 64'(count), 64'd0);
`endif
        rst = 1'b1;
        m_state = SEED_DEF;
        m_tog   = 1'b0;
        clear_q();

        // First sample after reset, with latency check
        pushin = 1'b1; t0 = cyc;
        tick();
        pushin = 1'b0;
        model_sample();
        repeat (6) tick();
        compare_caps("first");
        if (cap_cyc.size() > 0) chk("first_latency", 64'(cap_cyc[0] - t0), 64'd3);

        // Seed 1: hand-computed value
        do_reset();
        seed_ld = 1'b1; seed = 64'd1;
        tick();
        seed_ld = 1'b0; pushin = 1'b1;
        tick();
        pushin = 1'b0;
        repeat (6) tick();
        chk("seed1_nsamples", 64'(cap_num.size()), 64'd1);
        if (cap_num.size() > 0) begin
            chk("seed1_num", cap_num[0], 64'h3DD0208810400000);
            chk("seed1_sel", 64'(cap_sel[0]), 64'd0);
        end

        // 1000 back-to-back samples
        do_reset();
        pushin = 1'b1; t0 = cyc;
        repeat (1000) begin
            tick();
            model_sample();
        end
        pushin = 1'b0;
        repeat (6) tick();
        compare_caps("b2b");
        for (int i = 0; i < cap_num.size(); i++) begin
            chk($sformatf("b2b_cyc[%0d]", i), 64'(cap_cyc[i]), 64'(t0 + 3 + i));
            chk($sformatf("b2b_range[%0d]", i),
                64'((cap_num[i][63] == 1'b0) && (cap_num[i][62:52] >= 11'd959) &&
                    (cap_num[i][62:52] <= 11'd1022) && ($bitstoreal(cap_num[i]) < 1.0)),
                64'd1);
        end

        // Zero seed: same-cycle pushin dropped, sequence restarts from the default seed
        clear_q();
        m_state = SEED_DEF;
        seed_ld = 1'b1; seed = 64'd0; pushin = 1'b1;
        tick();
        seed_ld = 1'b0;
        repeat (4) begin
            tick();
            model_sample();
        end
        pushin = 1'b0;
        repeat (6) tick();
        compare_caps("zseed");

        // Reset while two samples are in flight
        clear_q();
        pushin = 1'b1;
        tick(); tick();
        pushin = 1'b0; rst = 1'b0;
        tick();
        rst = 1'b1;
        repeat (4) tick();
        chk("midrst_dropped", 64'(cap_num.size()), 64'd0);
        clear_q();
        m_state = SEED_DEF; m_tog = 1'b0;
        pushin = 1'b1;
        tick();
        pushin = 1'b0;
        model_sample();
        repeat (6) tick();
        compare_caps("midrst_after");

`ifdef URNG_STATS_EN
        // Counter wrap from a preloaded value
        do_reset();
        force dut.count_q = 32'hFFFFFFFE;
        tick();
        release dut.count_q;
        pushin = 1'b1;
        repeat (3) tick();
        pushin = 1'b0;
        repeat (6) tick();
        chk("cnt_nsamples", 64'(cap_cnt.size()), 64'd3);
        if (cap_cnt.size() >= 3) begin
            chk("cnt0", 64'(cap_cnt[0]), 64'hFFFFFFFF);
            chk("cnt1", 64'(cap_cnt[1]), 64'h0);
            chk("cnt2", 64'(cap_cnt[2]), 64'h1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
